// File: rtl/operand_sequencer.sv
// operand_sequencer: buffers operand pairs in a 4-entry FIFO and, on start,
// sequences clr/ld into an external datapath one pair at a time, capturing
// the datapath outputs into result registers with a one-cycle valid strobe.
module operand_sequencer #(
    parameter int WIDTH = 8,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             start,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             dp_ld,
    output logic             dp_clr,
    input  logic [WIDTH-1:0] dp_outA,
    input  logic [WIDTH-1:0] dp_outB,
    input  logic [WIDTH-1:0] dp_outC,
    output logic [WIDTH-1:0] res_a,
    output logic [WIDTH-1:0] res_b,
    output logic [WIDTH-1:0] res_c,
    output logic             res_valid,
    output logic [7:0]       res_count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_WAIT,
        S_CAPT,
        S_DONE
    } state_e;

    // WAIT lasts LAT cycles, so the counter starts one below LAT.
    localparam logic [3:0] WAIT_INIT = 4'(LAT - 1);

    state_e               state_q, state_d;
    logic [3:0]           wait_q, wait_d;

    logic [2*WIDTH-1:0]   mem_q [4];
    logic [1:0]           wr_ptr_q, rd_ptr_q;
    logic [2:0]           count_q, count_d;
    logic                 push, pop;
    logic [2*WIDTH-1:0]   head;

    logic [WIDTH-1:0]     res_a_q, res_b_q, res_c_q;
    logic                 res_valid_q;
    logic [7:0]           res_count_q;

    assign in_ready = (count_q < 3'd4);
    assign push     = in_valid && in_ready;
    // The head leaves the FIFO at the edge that ends LOAD; the FSM only
    // enters LOAD with at least one entry queued.
    assign pop      = (state_q == S_LOAD);
    assign head     = mem_q[rd_ptr_q];

    // FIFO occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy register.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q <= count_d;
        end
    end

    // FIFO storage write.
    // NOTE: the storage array has no reset; emptiness is tracked by count_q and
    // the head only reaches dp_a/dp_b while LOAD, so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {a_in, b_in};
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic and Moore outputs.
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        dp_a    = '0;
        dp_b    = '0;
        dp_ld   = 1'b0;
        dp_clr  = 1'b0;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = (count_q != 3'd0) ? S_CLR : S_DONE;
            end
            S_CLR: begin
                dp_clr  = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                dp_ld   = 1'b1;
                dp_a    = head[2*WIDTH-1:WIDTH];
                dp_b    = head[WIDTH-1:0];
                wait_d  = WAIT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == 4'd0) state_d = S_CAPT;
                else                wait_d  = wait_q - 4'd1;
            end
            S_CAPT: begin
                // A pair pushed in this very cycle keeps the run going.
                state_d = ((count_q != 3'd0) || push) ? S_CLR : S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result capture, valid strobe and processed-pair counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_a_q     <= '0;
            res_b_q     <= '0;
            res_c_q     <= '0;
            res_valid_q <= 1'b0;
            res_count_q <= '0;
        end else begin
            res_valid_q <= (state_q == S_CAPT);
            if (state_q == S_CAPT) begin
                res_a_q     <= dp_outA;
                res_b_q     <= dp_outB;
                res_c_q     <= dp_outC;
                res_count_q <= res_count_q + 8'd1;
            end
        end
    end

    assign res_a     = res_a_q;
    assign res_b     = res_b_q;
    assign res_c     = res_c_q;
    assign res_valid = res_valid_q;
    assign res_count = res_count_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: two instances (LAT=1 and LAT=3) share the
// producer stimulus; a queue-based model predicts every output each cycle.
module tb_operand_sequencer;

    localparam int NI = 2;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } pair_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a_in = '0, b_in = '0;
    logic       in_valid = 1'b0, start = 1'b0;

    logic       in_ready [NI];
    logic [7:0] dp_a [NI], dp_b [NI];
    logic       dp_ld [NI], dp_clr [NI];
    logic [7:0] oa [NI], ob [NI], oc [NI];
    logic [7:0] res_a [NI], res_b [NI], res_c [NI];
    logic       res_valid [NI];
    logic [7:0] res_count [NI];
    logic       busy [NI], done [NI];

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc    = 0;
    bit chk_en  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    operand_sequencer #(.WIDTH(8), .LAT(1)) dut0 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
        .in_valid(in_valid), .in_ready(in_ready[0]), .start(start),
        .dp_a(dp_a[0]), .dp_b(dp_b[0]), .dp_ld(dp_ld[0]), .dp_clr(dp_clr[0]),
        .dp_outA(oa[0]), .dp_outB(ob[0]), .dp_outC(oc[0]),
        .res_a(res_a[0]), .res_b(res_b[0]), .res_c(res_c[0]),
        .res_valid(res_valid[0]), .res_count(res_count[0]),
        .busy(busy[0]), .done(done[0])
    );

    operand_sequencer #(.WIDTH(8), .LAT(3)) dut1 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
        .in_valid(in_valid), .in_ready(in_ready[1]), .start(start),
        .dp_a(dp_a[1]), .dp_b(dp_b[1]), .dp_ld(dp_ld[1]), .dp_clr(dp_clr[1]),
        .dp_outA(oa[1]), .dp_outB(ob[1]), .dp_outC(oc[1]),
        .res_a(res_a[1]), .res_b(res_b[1]), .res_c(res_c[1]),
        .res_valid(res_valid[1]), .res_count(res_count[1]),
        .busy(busy[1]), .done(done[1])
    );

    // Datapath stand-in: ld registers A, B, A+B; clr zeroes all three.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (dp_clr[k]) begin
                oa[k] <= '0; ob[k] <= '0; oc[k] <= '0;
            end else if (dp_ld[k]) begin
                oa[k] <= dp_a[k];
                ob[k] <= dp_b[k];
                oc[k] <= dp_a[k] + dp_b[k];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A run is a sequence of pair slots of LAT+3 cycles: slot offset 0 is the
    // clear cycle, 1 the load cycle, LAT+2 the capture cycle.
    pair_t      mq [NI][$];
    bit         m_run [NI]   = '{0, 0};
    int         m_tick [NI]  = '{0, 0};
    bit         m_done [NI]  = '{0, 0};
    bit         m_valid [NI] = '{0, 0};
    pair_t      m_cur [NI]   = '{'0, '0};
    pair_t      m_res [NI]   = '{'0, '0};
    logic [7:0] m_resc [NI]  = '{'0, '0};
    logic [7:0] m_cnt [NI]   = '{'0, '0};

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    always @(posedge clk or negedge reset) begin
        bit push, was_done;
        if (!reset) begin
            for (int k = 0; k < NI; k++) begin
                mq[k].delete();
                m_run[k] = 0; m_tick[k] = 0; m_done[k] = 0; m_valid[k] = 0;
                m_res[k] = '0; m_resc[k] = '0; m_cnt[k] = '0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                push     = in_valid && (mq[k].size() < 4);
                was_done = m_done[k];
                m_done[k]  = 0;
                m_valid[k] = 0;
                if (m_run[k]) begin
                    if (m_tick[k] == 1) m_cur[k] = mq[k].pop_front();
                    if (m_tick[k] == lat_of(k) + 2) begin
                        m_valid[k] = 1;
                        m_res[k]   = m_cur[k];
                        m_resc[k]  = m_cur[k].a + m_cur[k].b;
                        m_cnt[k]   = m_cnt[k] + 8'd1;
                        if (mq[k].size() > 0 || push) m_tick[k] = 0;
                        else begin m_run[k] = 0; m_done[k] = 1; end
                    end else begin
                        m_tick[k]++;
                    end
                end else if (!was_done && start) begin
                    if (mq[k].size() > 0) begin m_run[k] = 1; m_tick[k] = 0; end
                    else m_done[k] = 1;
                end
                if (push) mq[k].push_back({a_in, b_in});
            end
        end
    end

    // Event log used by the hand-computed checks.
    int         vcnt [NI] = '{0, 0};
    int         dcnt [NI] = '{0, 0};
    int         ev_cyc [$];
    logic [7:0] ev_c [$];
    bit         ev_done [$];

    task automatic clear_log();
        vcnt = '{0, 0};
        dcnt = '{0, 0};
        ev_cyc.delete(); ev_c.delete(); ev_done.delete();
    endtask

    // Compare process: every output of both instances against the model.
    always @(negedge clk) begin
        bit    eld, eclr;
        pair_t h;
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                eclr = m_run[k] && (m_tick[k] == 0);
                eld  = m_run[k] && (m_tick[k] == 1);
                h    = (eld && mq[k].size() > 0) ? mq[k][0] : '0;
                check($sformatf("in_ready%0d", k), in_ready[k], mq[k].size() < 4);
                check($sformatf("busy%0d", k), busy[k], m_run[k] || m_done[k]);
                check($sformatf("done%0d", k), done[k], m_done[k]);
                check($sformatf("dp_clr%0d", k), dp_clr[k], eclr);
                check($sformatf("dp_ld%0d", k), dp_ld[k], eld);
                check($sformatf("dp_a%0d", k), dp_a[k], h.a);
                check($sformatf("dp_b%0d", k), dp_b[k], h.b);
                check($sformatf("res_valid%0d", k), res_valid[k], m_valid[k]);
                check($sformatf("res_a%0d", k), res_a[k], m_res[k].a);
                check($sformatf("res_b%0d", k), res_b[k], m_res[k].b);
                check($sformatf("res_c%0d", k), res_c[k], m_resc[k]);
                check($sformatf("res_count%0d", k), res_count[k], m_cnt[k]);
                if (res_valid[k]) vcnt[k]++;
                if (done[k]) dcnt[k]++;
            end
            if (res_valid[0]) begin
                ev_cyc.push_back(ncyc + 1);
                ev_c.push_back(res_c[0]);
                ev_done.push_back(done[0]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        in_valid = 0; start = 0;
        reset = 0;
        tick(); tick();
        reset = 1;
        tick();
        clear_log();
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        bit ok;
        ok = 0;
        a_in = a; b_in = b; in_valid = 1;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = in_ready[0];
            tick();
        end
        in_valid = 0;
        check("push_accepted", ok, 1);
    endtask

    task automatic pulse_start(output int t);
        start = 1;
        tick();
        start = 0;
        t = ncyc;
    endtask

    task automatic wait_events(input int n, input int budget);
        for (int i = 0; i < budget && ev_c.size() < n; i++) @(negedge clk);
        #1;
        check("event_count", ev_c.size(), n);
    endtask

    int           t;
    logic [7:0]   exp_c [5];

    initial begin
        #1 reset = 0;
        #1 chk_en = 1;

        // Reset held 100 ns, then release.
        repeat (10) @(posedge clk);
        #2 reset = 1;
        tick();
        clear_log();
        check("rst_in_ready", in_ready[0], 1);
        check("rst_busy", busy[0], 0);
        check("rst_res_count", res_count[0], 0);
        check("rst_res_c", res_c[0], 0);
        pulse_start(t);
        @(negedge clk);
        check("empty_start_done", done[0], 1);
        check("empty_start_count", res_count[0], 0);
        tick(); tick();

        // Single pair.
        do_reset();
        push(8'd9, 8'd2);
        pulse_start(t);
        @(negedge clk);
        check("single_clr", dp_clr[0], 1);
        @(negedge clk);
        check("single_ld", dp_ld[0], 1);
        check("single_dp_a", dp_a[0], 9);
        check("single_dp_b", dp_b[0], 2);
        wait_events(1, 30);
        if (ev_c.size() >= 1) begin
            check("single_latency", ev_cyc[0] - t, 5);
            check("single_res_c", ev_c[0], 11);
            check("single_done_with_valid", ev_done[0], 1);
        end
        tick(); tick();
        check("single_count", res_count[0], 1);

        // Three pairs, including an 8-bit wrap of the sum.
        do_reset();
        push(8'd9, 8'd2); push(8'd245, 8'd4); push(8'd235, 8'd251);
        pulse_start(t);
        wait_events(3, 60);
        exp_c[0] = 11; exp_c[1] = 249; exp_c[2] = 230;
        if (ev_c.size() >= 3) begin
            for (int i = 0; i < 3; i++) check($sformatf("three_res_c%0d", i), ev_c[i], exp_c[i]);
            check("three_gap1", ev_cyc[1] - ev_cyc[0], 4);
            check("three_gap2", ev_cyc[2] - ev_cyc[1], 4);
        end
        tick(); tick();
        check("three_count", res_count[0], 3);
        check("three_done_once", dcnt[0], 1);

        // FIFO full: fifth pair held until the first pop.
        do_reset();
        push(8'd1, 8'd2); push(8'd3, 8'd4); push(8'd5, 8'd6); push(8'd7, 8'd8);
        check("full_in_ready", in_ready[0], 0);
        a_in = 8'd200; b_in = 8'd100; in_valid = 1;
        repeat (3) begin
            tick();
            check("full_held", in_ready[0], 0);
        end
        pulse_start(t);
        push(8'd200, 8'd100);
        wait_events(5, 100);
        exp_c[0] = 3; exp_c[1] = 7; exp_c[2] = 11; exp_c[3] = 15; exp_c[4] = 44;
        if (ev_c.size() >= 5)
            for (int i = 0; i < 5; i++) check($sformatf("full_res_c%0d", i), ev_c[i], exp_c[i]);
        tick(); tick();
        check("full_count", res_count[0], 5);

        // Push during WAIT of the last pair, plus a start while busy.
        do_reset();
        push(8'd10, 8'd20);
        pulse_start(t);
        tick(); tick();
        start = 1; a_in = 8'd30; b_in = 8'd40; in_valid = 1;
        tick();
        start = 0; in_valid = 0;
        wait_events(2, 40);
        repeat (20) tick();
        if (ev_c.size() >= 2) begin
            check("midrun_res_c0", ev_c[0], 30);
            check("midrun_res_c1", ev_c[1], 70);
            check("midrun_no_gap", ev_cyc[1] - ev_cyc[0], 4);
        end
        check("midrun_done_once", dcnt[0], 1);
        check("midrun_count", res_count[0], 2);
        check("midrun_count_lat3", res_count[1], 2);

        // Reset during WAIT of the first of three pairs, LAT=3 instance.
        push(8'd11, 8'd12); push(8'd13, 8'd14); push(8'd15, 8'd16);
        pulse_start(t);
        tick(); tick();
        check("abort_busy_before", busy[1], 1);
        reset = 0;
        #1;
        check("abort_busy", busy[1], 0);
        check("abort_count", res_count[1], 0);
        check("abort_in_ready", in_ready[1], 1);
        check("abort_res_c", res_c[1], 0);
        tick(); tick();
        reset = 1;
        clear_log();
        repeat (40) tick();
        check("abort_no_valid", vcnt[1], 0);
        check("abort_no_done", dcnt[1], 0);

        // Randomised traffic, with one reset in the middle.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            start    = ($urandom_range(0, 5) == 0);
            if (i == 1000) reset = 0;
            if (i == 1003) reset = 1;
            tick();
        end
        in_valid = 0; start = 0;
        repeat (40) tick();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
